// File: rtl/hazard_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit_if
//
// Purpose: groups every signal exchanged between the pipeline datapath and
// the load-use / flush hazard unit, so both sides connect through one port.
//
// Parameters:
//   REG_ADDR_W  register-address width
//   CNT_W       width of the stall-cycle counter output
//
// Signals (direction as seen by the hazard unit, modport slave):
//   id_rs, id_rt      in   source register fields of the IF/ID instruction
//   id_uses_rt        in   IF/ID instruction reads rt as a source
//   ex_rt             in   destination register of the ID/EX instruction
//   ex_mem_read       in   ID/EX instruction is a load
//   ex_branch_taken   in   branch/jump resolved taken in EX
//   pc_write          out  PC update enable
//   ifid_write        out  IF/ID load enable
//   ctrl_mux          out  0 selects a bubble into ID/EX
//   ifid_flush        out  clear IF/ID to a NOP
//   stall_active      out  unit is in its multi-cycle STALL state
//   stall_cycles      out  accumulated stall-cycle count
//
// The master modport is the datapath side driving the hazard inputs.
// ---------------------------------------------------------------------------
interface hazard_ctrl_unit_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_mem_read;
    logic                  ex_branch_taken;
    logic                  pc_write;
    logic                  ifid_write;
    logic                  ctrl_mux;
    logic                  ifid_flush;
    logic                  stall_active;
    logic [CNT_W-1:0]      stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, ex_branch_taken,
        input  pc_write, ifid_write, ctrl_mux, ifid_flush, stall_active,
               stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, ex_branch_taken,
        output pc_write, ifid_write, ctrl_mux, ifid_flush, stall_active,
               stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_unit
//
// Purpose: load-use hazard and control-flush unit for the 5-stage pipeline.
// A load in ID/EX whose destination feeds the IF/ID instruction freezes PC
// and IF/ID and injects LOAD_STALL bubbles into ID/EX. Register 0 never
// causes a hazard. A taken branch in EX flushes IF/ID and bubbles ID/EX for
// one cycle and overrides (or aborts) any stall.
//
// Parameters:
//   REG_ADDR_W  register-address width
//   LOAD_STALL  bubbles per load-use hazard, 1..7
//   CNT_W       stall counter width (only meaningful with the counter built)
//
// Ports:
//   clk    pipeline clock, rising edge
//   reset  synchronous, active-low; also forces all enables low while held
//   bus    hazard_ctrl_unit_if.slave, see the interface file
//
// Build option: define HAZARD_PERF_CNT_EN to build a saturating counter of
// stall cycles on bus.stall_cycles; otherwise that output is constant 0.
// ---------------------------------------------------------------------------
module hazard_ctrl_unit #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 32
) (
    input logic               clk,
    input logic               reset,
    hazard_ctrl_unit_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } stateT;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG   = '0;
    localparam logic [2:0]            STALL_INIT = 3'(LOAD_STALL - 1);

    stateT      state;
    stateT      stateNext;
    logic [2:0] rem;
    logic [2:0] remNext;
    logic       hazard;
    logic       pcWrite;
    logic       ifidWrite;
    logic       ctrlMux;
    logic       ifidFlush;
    logic       stallActive;

    // A load whose non-zero destination matches a source the ID instruction
    // actually reads; rt only counts when the instruction uses it.
    assign hazard = bus.ex_mem_read && (bus.ex_rt != ZERO_REG) &&
                    ((bus.ex_rt == bus.id_rs) ||
                     (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));

    // State register and remaining-bubble counter. Reset drops any stall in
    // progress so nothing of an old hazard survives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            rem   <= 3'd0;
        end else begin
            state <= stateNext;
            rem   <= remNext;
        end
    end

    // Next-state and output decode. The first bubble is produced in IDLE in
    // the cycle the hazard is seen; the STALL state supplies the remaining
    // LOAD_STALL-1 bubbles and ignores the comparators because ID/EX holds a
    // bubble by then. A taken branch wins everywhere and ends a stall early.
    always_comb begin
        stateNext   = state;
        remNext     = rem;
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        ctrlMux     = 1'b1;
        ifidFlush   = 1'b0;
        stallActive = 1'b0;

        if (!reset) begin
            pcWrite   = 1'b0;
            ifidWrite = 1'b0;
            ctrlMux   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ex_branch_taken) begin
                        ifidFlush = 1'b1;
                        ctrlMux   = 1'b0;
                    end else if (hazard) begin
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        ctrlMux   = 1'b0;
                        if (LOAD_STALL > 1) begin
                            stateNext = STALL;
                            remNext   = STALL_INIT;
                        end
                    end
                end
                STALL: begin
                    stallActive = 1'b1;
                    if (bus.ex_branch_taken) begin
                        ifidFlush = 1'b1;
                        ctrlMux   = 1'b0;
                        stateNext = IDLE;
                        remNext   = 3'd0;
                    end else begin
                        pcWrite   = 1'b0;
                        ifidWrite = 1'b0;
                        ctrlMux   = 1'b0;
                        remNext   = rem - 3'd1;
                        if (rem == 3'd1) begin
                            stateNext = IDLE;
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                    remNext   = 3'd0;
                end
            endcase
        end
    end

    assign bus.pc_write     = pcWrite;
    assign bus.ifid_write   = ifidWrite;
    assign bus.ctrl_mux     = ctrlMux;
    assign bus.ifid_flush   = ifidFlush;
    assign bus.stall_active = stallActive;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt;

    // Out of reset, pc_write low only ever comes from a hazard bubble or a
    // STALL cycle, so it marks exactly the cycles to count. Flush cycles keep
    // pc_write high and are skipped. The count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stallCnt <= '0;
        end else if (!pcWrite && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.stall_cycles = stallCnt;
`else
    assign bus.stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl_unit
//
// Purpose: directed scoreboard bench for hazard_ctrl_unit. Three instances
// share one input stream and one reset: LOAD_STALL=1 with a 2-bit counter,
// LOAD_STALL=3 and LOAD_STALL=4. Each stimulus cycle pushes hand-computed
// expectations for the instance under test; a negedge monitor pops and
// compares them. Counter expectations collapse to 0 unless
// HAZARD_PERF_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    // Packed output order: {pc_write, ifid_write, ctrl_mux, ifid_flush,
    // stall_active}
    localparam logic [4:0] RUN   = 5'b11100;
    localparam logic [4:0] BUB   = 5'b00000;
    localparam logic [4:0] STL   = 5'b00001;
    localparam logic [4:0] FLS   = 5'b11010;
    localparam logic [4:0] FLS_S = 5'b11011;
    localparam logic [4:0] OFF   = 5'b00000;

    typedef struct {
        int          dut;
        logic [4:0]  outs;
        bit          cntCare;
        logic [31:0] cnt;
        string       name;
    } expT;

    logic clk;
    logic reset;
    expT  sb[$];
    int   checkCount = 0;
    int   passCount  = 0;

    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(2))  if1();
    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) if3();
    hazard_ctrl_unit_if #(.REG_ADDR_W(5), .CNT_W(32)) if4();

    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave)
    );
    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL(3), .CNT_W(32)) dut3 (
        .clk(clk), .reset(reset), .bus(if3.slave)
    );
    hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL(4), .CNT_W(32)) dut4 (
        .clk(clk), .reset(reset), .bus(if4.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation still running, required to finish");
        $fatal(1, "[TB] timeout");
    end

    // Drives one cycle of shared inputs, just after the rising edge.
    task automatic applyStimulus(input logic rstN, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic usesRt,
                                 input logic [4:0] exRt, input logic memRd,
                                 input logic br);
        @(posedge clk);
        #1;
        reset = rstN;
        if1.id_rs = rs; if1.id_rt = rt; if1.id_uses_rt = usesRt;
        if1.ex_rt = exRt; if1.ex_mem_read = memRd; if1.ex_branch_taken = br;
        if3.id_rs = rs; if3.id_rt = rt; if3.id_uses_rt = usesRt;
        if3.ex_rt = exRt; if3.ex_mem_read = memRd; if3.ex_branch_taken = br;
        if4.id_rs = rs; if4.id_rt = rt; if4.id_uses_rt = usesRt;
        if4.ex_rt = exRt; if4.ex_mem_read = memRd; if4.ex_branch_taken = br;
    endtask

    task automatic idleCycle(input logic rstN);
        applyStimulus(rstN, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b0);
    endtask

    task automatic expectOut(input int dut, input logic [4:0] outs,
                             input bit cntCare, input logic [31:0] cnt,
                             input string name);
        expT e;
        e.dut     = dut;
        e.outs    = outs;
        e.cntCare = cntCare;
`ifdef HAZARD_PERF_CNT_EN
        e.cnt     = cnt;
`else
        e.cnt     = 32'd0;
`endif
        e.name    = name;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input expT e);
        logic [4:0]  act;
        logic [31:0] actCnt;
        bit          ok;
        case (e.dut)
            1: begin
                act = {if1.pc_write, if1.ifid_write, if1.ctrl_mux,
                       if1.ifid_flush, if1.stall_active};
                actCnt = 32'(if1.stall_cycles);
            end
            3: begin
                act = {if3.pc_write, if3.ifid_write, if3.ctrl_mux,
                       if3.ifid_flush, if3.stall_active};
                actCnt = if3.stall_cycles;
            end
            default: begin
                act = {if4.pc_write, if4.ifid_write, if4.ctrl_mux,
                       if4.ifid_flush, if4.stall_active};
                actCnt = if4.stall_cycles;
            end
        endcase
        ok = (act === e.outs) && (!e.cntCare || (actCnt === e.cnt));
        checkCount++;
        if (ok) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s (dut LOAD_STALL=%0d): got outs=%b cnt=%0d, expected outs=%b cnt=%0d%s",
                     e.name, e.dut, act, actCnt, e.outs, e.cnt,
                     e.cntCare ? "" : " (cnt not checked)");
        end
    endtask

    // Monitor: every entry pushed this cycle is checked mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            checkOutput(sb.pop_front());
        end
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        expectOut(3, OFF, 1, 0, "rst_hold1");
        applyStimulus(1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        expectOut(3, OFF, 1, 0, "rst_hold2");
        applyStimulus(1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        expectOut(3, OFF, 1, 0, "rst_hold3");
        expectOut(1, OFF, 1, 0, "rst_hold3_ls1");
        idleCycle(1'b1);
        expectOut(3, RUN, 1, 0, "rst_release");
        expectOut(1, RUN, 1, 0, "rst_release_ls1");
        expectOut(4, RUN, 1, 0, "rst_release_ls4");

        // LOAD_STALL=1: single bubble, no STALL state
        applyStimulus(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        expectOut(1, BUB, 1, 0, "ls1_rs_hazard");
        idleCycle(1'b1);
        expectOut(1, RUN, 1, 1, "ls1_recover");
        applyStimulus(1'b1, 5'd0, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0);
        expectOut(1, RUN, 1, 1, "ls1_rt_unused");
        applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        expectOut(1, RUN, 1, 1, "r0_exempt");
        applyStimulus(1'b1, 5'd7, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0);
        expectOut(1, RUN, 1, 1, "no_load");

        // LOAD_STALL=3: rt hazard, back-to-back hazards, flushes
        idleCycle(1'b0);
        expectOut(3, OFF, 0, 0, "rst_pulse_c");
        applyStimulus(1'b1, 5'd3, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0);
        expectOut(3, BUB, 1, 0, "ls3_detect");
        idleCycle(1'b1);
        expectOut(3, STL, 1, 1, "ls3_stall1");
        idleCycle(1'b1);
        expectOut(3, STL, 1, 2, "ls3_stall2");
        idleCycle(1'b1);
        expectOut(3, RUN, 1, 3, "ls3_done");
        applyStimulus(1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        expectOut(3, BUB, 1, 3, "ls3_again");
        idleCycle(1'b1);
        expectOut(3, STL, 1, 4, "ls3_again_s1");
        applyStimulus(1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        expectOut(3, STL, 1, 5, "ls3_ignore_in_stall");
        applyStimulus(1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        expectOut(3, BUB, 1, 6, "ls3_reeval");
        idleCycle(1'b1);
        expectOut(3, STL, 1, 7, "ls3_reeval_s1");
        idleCycle(1'b1);
        expectOut(3, STL, 1, 8, "ls3_reeval_s2");
        idleCycle(1'b1);
        expectOut(3, RUN, 1, 9, "ls3_reeval_done");
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1);
        expectOut(3, FLS, 1, 9, "flush_idle");
        applyStimulus(1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        expectOut(3, FLS, 1, 9, "flush_over_hazard");
        idleCycle(1'b1);
        expectOut(3, RUN, 1, 9, "after_flush");

        // LOAD_STALL=4: branch in the first STALL-state cycle aborts
        idleCycle(1'b0);
        expectOut(4, OFF, 0, 0, "rst_pulse_d");
        applyStimulus(1'b1, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        expectOut(4, BUB, 1, 0, "ls4_detect");
        applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 1'b1);
        expectOut(4, FLS_S, 1, 1, "ls4_abort");
        idleCycle(1'b1);
        expectOut(4, RUN, 1, 1, "ls4_after_abort");
        idleCycle(1'b1);
        expectOut(4, RUN, 1, 1, "ls4_stays_idle");

        // CNT_W=2 saturation on the LOAD_STALL=1 instance
        idleCycle(1'b0);
        expectOut(1, OFF, 0, 0, "rst_pulse_e");
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
            expectOut(1, BUB, 1, 32'((k - 1 > 3) ? 3 : k - 1), "sat_hazard");
            idleCycle(1'b1);
            expectOut(1, RUN, 1, 32'((k > 3) ? 3 : k), "sat_idle");
        end

        // Reset in the middle of a stall
        idleCycle(1'b0);
        expectOut(3, OFF, 0, 0, "rst_pulse_f");
        applyStimulus(1'b1, 5'd2, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        expectOut(3, BUB, 1, 0, "mid_detect");
        idleCycle(1'b1);
        expectOut(3, STL, 1, 1, "mid_stall1");
        idleCycle(1'b0);
        expectOut(3, OFF, 1, 2, "mid_reset");
        idleCycle(1'b1);
        expectOut(3, RUN, 1, 0, "mid_release");
        idleCycle(1'b1);
        expectOut(3, RUN, 1, 0, "mid_release2");

        // Let the monitor drain the scoreboard, bounded
        for (int w = 0; w < 10 && sb.size() > 0; w++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (sb.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised load-use hazard and control-flush unit for the 32-bit 5-stage pipeline, sitting between the IF/ID, ID/EX and EX stage registers. It generalises single-cycle load-use stalling to a configurable multi-cycle stall, ignores register 0, and adds a branch-taken flush path with priority over stalls. An optional saturating counter records stall cycles for performance analysis.

## Interface
Parameters:
- REG_ADDR_W, 5, register-address width.
- LOAD_STALL, 1, bubble cycles per load-use hazard; legal range 1..7.
- CNT_W, 32, stall-counter width. Used only when the counter is compiled in.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low.
- id_rs  input  REG_ADDR_W  rs field of the instruction in IF/ID.
- id_rt  input  REG_ADDR_W  rt field of the instruction in IF/ID.
- id_uses_rt  input  1  1 when the ID instruction reads rt as a source.
- ex_rt  input  REG_ADDR_W  destination of the instruction in ID/EX.
- ex_mem_read  input  1  instruction in ID/EX is a load.
- ex_branch_taken  input  1  branch or jump resolved taken in EX.
- pc_write  output  1  1 means PC updates.
- ifid_write  output  1  1 means IF/ID register loads.
- ctrl_mux  output  1  0 means zero the control into ID/EX (bubble).
- ifid_flush  output  1  1 means clear IF/ID to a NOP.
- stall_active  output  1  1 while the FSM is in STALL.
- stall_cycles  output  CNT_W  number of stall cycles (see Configuration).

## Operation
- hazard = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- FSM states are IDLE and STALL. There is a down-counter `rem`, 3 bits wide.
- IDLE:
  - If ex_branch_taken: ifid_flush=1, ctrl_mux=0, pc_write=1, ifid_write=1. Stay in IDLE.
  - Else if hazard: pc_write=0, ifid_write=0, ctrl_mux=0. If LOAD_STALL>1, go to STALL with rem=LOAD_STALL-1. Otherwise stay in IDLE.
  - Else: all enables are 1, ifid_flush=0.
- STALL:
  - pc_write=0, ifid_write=0, ctrl_mux=0, stall_active=1.
  - Hazard comparators are ignored here, because ID/EX now holds a bubble.
  - rem decrements each cycle. Leave for IDLE at the edge where rem==1.
- Simultaneous events:
  - ex_branch_taken has priority in every state. In STALL it aborts the stall: flush outputs as in IDLE, next state IDLE, rem=0.
  - A hazard detected in the cycle STALL exits is evaluated normally in the following IDLE cycle.
- Reset:
  - While reset==0, outputs are forced combinationally to pc_write=0, ifid_write=0, ctrl_mux=0, ifid_flush=0, stall_active=0.
  - At the next rising edge with reset==0: state=IDLE, rem=0, stall_cycles=0.
  - Reset mid-stall abandons the stall. No hazard state survives reset.

## Timing
- Detection is combinational. The first bubble appears in the same cycle the hazard is present.
- Total bubble cycles per hazard is exactly LOAD_STALL: 1 IDLE-detect cycle plus LOAD_STALL-1 STALL cycles.
- A flush lasts exactly one cycle per ex_branch_taken pulse.
- After reset deasserts, the first cycle is IDLE with all enables 1 unless a hazard or flush is present.
- stall_cycles updates one edge after each cycle with pc_write==0 due to a hazard or STALL. Reset cycles and flush cycles are not counted.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments by 1 on each counted cycle.
  - It saturates at 2^CNT_W-1 and does not wrap.
- HAZARD_PERF_CNT_EN undefined:
  - stall_cycles is tied to 0 and no counter flops exist.
  - All other behaviour is identical.

## Test plan
- Reset: hold reset=0 for 3 cycles with a hazard present -> all outputs 0. After release with no hazard -> pc_write=ifid_write=ctrl_mux=1, stall_cycles=0.
- LOAD_STALL=1, ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> one cycle of pc_write=ifid_write=ctrl_mux=0, stall_active never 1. With id_rt=5, id_uses_rt=0 -> no stall.
- LOAD_STALL=3, hazard on rt=9 -> 3 consecutive stall cycles with stall_active=1 in cycles 2-3, then enables return to 1. With the counter compiled in, stall_cycles=3.
- ex_rt=0, ex_mem_read=1, id_rs=0 -> no stall (register 0 exempt).
- LOAD_STALL=4, ex_branch_taken=1 in the 2nd STALL cycle -> ifid_flush=1 and ctrl_mux=0 that cycle, pc_write=1, next state IDLE, stall_cycles=1.
- CNT_W=2 with the counter compiled in, 5 single-cycle hazards -> stall_cycles saturates at 3.
